// File: rtl/lab2_proc_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab2_proc_hazard_pkg
// Description : Shared types and constants for the pipeline hazard unit.
//               BYP_* encode the D-stage operand bypass-mux selects;
//               stage_ctrl_t is the control word carried per stage X/M/W.
// Revision    : 1.0 - initial release
// ============================================================================
package lab2_proc_hazard_pkg;

    localparam int ADDR_NBITS = 5;

    localparam logic [1:0] BYP_RF = 2'd0;
    localparam logic [1:0] BYP_X  = 2'd1;
    localparam logic [1:0] BYP_M  = 2'd2;
    localparam logic [1:0] BYP_W  = 2'd3;

    typedef struct packed {
        logic                  val;
        logic                  wen;
        logic [ADDR_NBITS-1:0] rd;
        logic                  is_load;
    } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/lab2_proc_stage_ctrl_reg.sv
`default_nettype none
// ============================================================================
// Module      : lab2_proc_stage_ctrl_reg
// Description : One pipeline stage's control register. Holds when en_i is
//               low; when loading with bubble_i high the stage becomes
//               invalid (val=0). Asynchronous active-high reset clears it.
// Ports       : clk, reset      clock / async active-high reset
//               en_i            load enable (= !stall of this stage)
//               bubble_i        load an invalid instruction instead of d_i
//               d_i / q_o       control word in / out
// Revision    : 1.0 - initial release
// ============================================================================
module lab2_proc_stage_ctrl_reg
    import lab2_proc_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        bubble_i,
    input  stage_ctrl_t d_i,
    output stage_ctrl_t q_o
);

    stage_ctrl_t ctrl_q;
    stage_ctrl_t ctrl_d;

    always_comb begin
        ctrl_d = ctrl_q;
        if (en_i) begin
            ctrl_d = d_i;
            if (bubble_i) begin
                ctrl_d.val = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign q_o = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/lab2_proc_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : lab2_proc_hazard_unit
// Description : Scoreboard / hazard controller for the 5-stage pipeline.
//               Tracks {val,wen,rd,is_load} of X/M/W, drives D-stage bypass
//               selects, stalls, bubbles, register enables and W writeback.
// Config      : PROC_BYPASS_EN defined -> full bypassing, load-use stall only.
//               Undefined (default)    -> no bypass, stall on any RAW in X/M/W.
// Ports       : clk, reset (async, active-high); D-stage decoded fields
//               val_D rs1_en_D rs1_D rs2_en_D rs2_D rf_wen_D rd_D is_load_D
//               squash_D; ext_stall_M, ext_stall_W; outputs op1/op2_byp_sel_D,
//               stall_D, reg_en_F/D/X/M/W, val_X/M/W, rf_wen_W, rf_waddr_W.
// Revision    : 1.0 - initial release
// ============================================================================
module lab2_proc_hazard_unit
    import lab2_proc_hazard_pkg::*;
#(
    parameter int p_addr_nbits = ADDR_NBITS,
    parameter bit p_zero_reg   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    val_D,
    input  logic                    rs1_en_D,
    input  logic [p_addr_nbits-1:0] rs1_D,
    input  logic                    rs2_en_D,
    input  logic [p_addr_nbits-1:0] rs2_D,
    input  logic                    rf_wen_D,
    input  logic [p_addr_nbits-1:0] rd_D,
    input  logic                    is_load_D,
    input  logic                    squash_D,
    input  logic                    ext_stall_M,
    input  logic                    ext_stall_W,
    output logic [1:0]              op1_byp_sel_D,
    output logic [1:0]              op2_byp_sel_D,
    output logic                    stall_D,
    output logic                    reg_en_F,
    output logic                    reg_en_D,
    output logic                    reg_en_X,
    output logic                    reg_en_M,
    output logic                    reg_en_W,
    output logic                    val_X,
    output logic                    val_M,
    output logic                    val_W,
    output logic                    rf_wen_W,
    output logic [p_addr_nbits-1:0] rf_waddr_W
);

    stage_ctrl_t w_ctrl_D, w_ctrl_X, w_ctrl_M, w_ctrl_W;
    logic w_stall_X, w_stall_M, w_stall_W, w_stall_D, w_hazard_D;
    logic w_m1_X, w_m1_M, w_m1_W, w_m2_X, w_m2_M, w_m2_W;
    logic w_unused;

    function automatic logic f_match(input logic                    en,
                                     input logic [p_addr_nbits-1:0] rs,
                                     input logic                    vd,
                                     input stage_ctrl_t             s);
        return en & vd & s.val & s.wen & (rs == s.rd) &
               !(p_zero_reg && (rs == '0));
    endfunction

    assign w_ctrl_D = '{val: val_D, wen: rf_wen_D, rd: rd_D, is_load: is_load_D};

    assign w_m1_X = f_match(rs1_en_D, rs1_D, val_D, w_ctrl_X);
    assign w_m1_M = f_match(rs1_en_D, rs1_D, val_D, w_ctrl_M);
    assign w_m1_W = f_match(rs1_en_D, rs1_D, val_D, w_ctrl_W);
    assign w_m2_X = f_match(rs2_en_D, rs2_D, val_D, w_ctrl_X);
    assign w_m2_M = f_match(rs2_en_D, rs2_D, val_D, w_ctrl_M);
    assign w_m2_W = f_match(rs2_en_D, rs2_D, val_D, w_ctrl_W);

`ifdef PROC_BYPASS_EN
    function automatic logic [1:0] f_sel(input logic mx, input logic mm, input logic mw);
        if (mx)      return BYP_X;
        else if (mm) return BYP_M;
        else if (mw) return BYP_W;
        else         return BYP_RF;
    endfunction

    assign op1_byp_sel_D = f_sel(w_m1_X, w_m1_M, w_m1_W);
    assign op2_byp_sel_D = f_sel(w_m2_X, w_m2_M, w_m2_W);
    // Only a load in X cannot be forwarded: its data appears in M.
    assign w_hazard_D    = (w_m1_X | w_m2_X) & w_ctrl_X.is_load;
`else
    assign op1_byp_sel_D = BYP_RF;
    assign op2_byp_sel_D = BYP_RF;
    assign w_hazard_D    = w_m1_X | w_m1_M | w_m1_W | w_m2_X | w_m2_M | w_m2_W;
`endif

    // External stalls are masked in reset so every enable reads 1 then.
    assign w_stall_W = ext_stall_W & ~reset;
    assign w_stall_M = (ext_stall_M & ~reset) | w_stall_W;
    assign w_stall_X = w_stall_M;
    // A squash kills the D instruction, so its hazard must not hold D.
    assign w_stall_D = (w_hazard_D & ~squash_D) | w_stall_X;

    lab2_proc_stage_ctrl_reg u_ctrl_X (
        .clk      (clk),
        .reset    (reset),
        .en_i     (~w_stall_X),
        .bubble_i (w_stall_D | squash_D),
        .d_i      (w_ctrl_D),
        .q_o      (w_ctrl_X)
    );

    lab2_proc_stage_ctrl_reg u_ctrl_M (
        .clk      (clk),
        .reset    (reset),
        .en_i     (~w_stall_M),
        .bubble_i (w_stall_X),
        .d_i      (w_ctrl_X),
        .q_o      (w_ctrl_M)
    );

    lab2_proc_stage_ctrl_reg u_ctrl_W (
        .clk      (clk),
        .reset    (reset),
        .en_i     (~w_stall_W),
        .bubble_i (w_stall_M),
        .d_i      (w_ctrl_M),
        .q_o      (w_ctrl_W)
    );

    assign stall_D    = w_stall_D;
    assign reg_en_F   = ~w_stall_D;
    assign reg_en_D   = ~w_stall_D;
    assign reg_en_X   = ~w_stall_X;
    assign reg_en_M   = ~w_stall_M;
    assign reg_en_W   = ~w_stall_W;
    assign val_X      = w_ctrl_X.val;
    assign val_M      = w_ctrl_M.val;
    assign val_W      = w_ctrl_W.val;
    assign rf_wen_W   = w_ctrl_W.val & w_ctrl_W.wen & ~w_stall_W;
    assign rf_waddr_W = w_ctrl_W.rd;

    // is_load is only consulted in X, and only when bypassing is built in.
    assign w_unused = ^{w_ctrl_X.is_load, w_ctrl_M.is_load, w_ctrl_W.is_load};

endmodule
`default_nettype wire
